muldiv_seq: RTL and testbench

MULDIV_SEQ -- requirements
Module: muldiv_seq

---
 rtl/muldiv_seq.sv | 143 ++++++++++++++
 tb/tb_muldiv_seq.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative 32-bit unsigned multiply/divide unit.
//   MUL/MULHU use one shift-add iteration per cycle on a 64-bit accumulator.
//   DIVU/REMU use one restoring shift-subtract iteration per cycle.
//   Every accepted operation finishes exactly 32 cycles after the accepting edge.
//
// Build option: define MULDIV_SEQ_DIV_EN to include the divide datapath.
//   Without it, DIVU/REMU are accepted and finish one state later with result 0.
//
// Ports:
//   clk     in   clock, rising edge
//   reset   in   synchronous, active-high reset
//   start   in   request a new operation (ignored while busy)
//   op[1:0] in   00 MUL, 01 MULHU, 10 DIVU, 11 REMU
//   a[31:0] in   multiplicand / dividend
//   b[31:0] in   multiplier / divisor
//   busy    out  operation in progress (RUN state)
//   done    out  one-cycle pulse, result valid (DONE state)
//   result  out  final result, held until the next completion or reset
module muldiv_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t      state, state_nxt;
  logic [5:0]  cnt;
  logic [63:0] acc;      // mul: {product hi, multiplier/product lo}; div: {rem, quo}
  logic [31:0] opnd;     // multiplicand or divisor
  logic        hi_q;     // op[0]: result comes from the upper half of acc
  logic        last;
  logic        fast_op;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [63:0] step_next;
  logic [31:0] res_sel;

`ifdef MULDIV_SEQ_DIV_EN
  logic        div_q;
  logic [32:0] rem_s;
  logic [32:0] diff;
  logic [63:0] div_next;
  assign fast_op = 1'b0;
`else
  // Divide ops have no datapath; they go straight to DONE with a zero result.
  assign fast_op = op[1];
`endif

  assign last = (cnt == 6'd31);

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: state_nxt = start ? (fast_op ? DONE : RUN) : IDLE;
      RUN:        if (last) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // ---------------- outputs ----------------
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // ---------------- iteration datapath ----------------
  // Shift-add: add multiplicand into the upper half when the multiplier LSB
  // is set, then shift the 65-bit {carry, acc} right by one.
  always_comb begin
    mul_sum  = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? opnd : 32'd0)};
    mul_next = {mul_sum, acc[31:1]};
  end

`ifdef MULDIV_SEQ_DIV_EN
  // Restoring divide: shift {rem, quo} left, trial-subtract on 33 bits.
  // With divisor 0 the subtract never borrows, giving quo = all ones and
  // rem = dividend, which is the required divide-by-zero behaviour.
  always_comb begin
    rem_s    = {acc[63:32], acc[31]};
    diff     = rem_s - {1'b0, opnd};
    div_next = diff[32] ? {rem_s[31:0], acc[30:0], 1'b0}
                        : {diff[31:0],  acc[30:0], 1'b1};
    step_next = div_q ? div_next : mul_next;
  end
`else
  assign step_next = mul_next;
`endif

  // MUL/DIVU take the low half, MULHU/REMU the high half.
  assign res_sel = hi_q ? step_next[63:32] : step_next[31:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      hi_q   <= 1'b0;
      result <= '0;
`ifdef MULDIV_SEQ_DIV_EN
      div_q  <= 1'b0;
`endif
    end else if (state == RUN) begin
      acc <= step_next;
      cnt <= cnt + 6'd1;
      if (last) result <= res_sel;
    end else if (start) begin
      hi_q <= op[0];
      cnt  <= '0;
`ifdef MULDIV_SEQ_DIV_EN
      div_q <= op[1];
      if (op[1]) begin
        acc  <= {32'd0, a};
        opnd <= b;
      end else begin
        acc  <= {32'd0, b};
        opnd <= a;
      end
`else
      if (op[1]) begin
        result <= '0;
      end else begin
        acc  <= {32'd0, b};
        opnd <= a;
      end
`endif
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: expected results are queued at the
// accepting edge and compared when done pulses, along with latency.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] res;
    int          acc_cyc;
    int          lat;
    string       tag;
  } exp_t;

  exp_t q[$];

  muldiv_seq dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    p = {32'd0, x} * {32'd0, y};
    case (o)
      2'd0: model = p[31:0];
      2'd1: model = p[63:32];
`ifdef MULDIV_SEQ_DIV_EN
      2'd2: model = (y == 0) ? 32'hFFFF_FFFF : x / y;
      default: model = (y == 0) ? x : x % y;
`else
      default: model = 32'd0;
`endif
    endcase
  endfunction

  function automatic bit is_fast(input logic [1:0] o);
`ifdef MULDIV_SEQ_DIV_EN
    is_fast = 1'b0;
`else
    is_fast = o[1];
`endif
  endfunction

  // Scoreboard monitor: every done pulse must match the head of the queue.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (q.size() == 0) begin
        chk("spurious_done", done, 1'b0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk({e.tag, ":res"}, result, e.res);
        chk({e.tag, ":lat"}, cyc - e.acc_cyc, e.lat);
        chk({e.tag, ":busy_at_done"}, busy, 1'b0);
      end
    end
  end

  // Drive start away from the clock edge; operands are scrambled right after
  // acceptance so a design that does not latch them gives a wrong result.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input string tag);
    exp_t e;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
    e.res = model(o, x, y);
    e.acc_cyc = cyc;
    e.lat = is_fast(o) ? 0 : 32;
    e.tag = tag;
    q.push_back(e);
    chk({tag, ":busy_after_accept"}, busy, !is_fast(o));
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", q.size(), 0);
      q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int n;
    logic [1:0] ro;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst:busy", busy, 1'b0);
    chk("rst:done", done, 1'b0);
    chk("rst:result", result, 32'd0);

    // MUL 7x6 with busy window and hold of result afterwards
    issue(2'd0, 32'd7, 32'd6, "mul7x6");
    repeat (32) @(negedge clk);
    chk("mul7x6:busy_k31", busy, 1'b1);
    chk("mul7x6:done_k31", done, 1'b0);
    drain();
    chk("mul7x6:held", result, 32'h2A);
    chk("mul7x6:idle_busy", busy, 1'b0);

    // MULHU max*max, then MUL started during DONE (zero bubble)
    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_max");
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 40);
    chk("mulhu_max:done_seen", done, 1'b1);
    issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_max_b2b");
    drain();

    // Divide ops, including divide by zero
    issue(2'd2, 32'd100, 32'd7, "divu100_7");  drain();
    issue(2'd3, 32'd100, 32'd7, "remu100_7");  drain();
    issue(2'd2, 32'd5,   32'd0, "divu5_0");    drain();
    issue(2'd3, 32'd5,   32'd0, "remu5_0");    drain();

    // Zero operands on multiply
    issue(2'd0, 32'd0, 32'h1234_5678, "mul_a0");   drain();
    issue(2'd1, 32'hDEAD_BEEF, 32'd0, "mulhu_b0"); drain();

    // start during RUN is ignored
    issue(2'd0, 32'd3, 32'd5, "mul3x5");
    repeat (9) @(negedge clk);
    start = 1'b1; op = 2'd1; a = 32'hFFFF_0000; b = 32'h0000_FFFF;
    @(posedge clk); #1;
    start = 1'b0;
    chk("mul3x5:still_busy", busy, 1'b1);
    drain();

    // Reset mid-RUN discards the operation
    issue(2'd0, 32'd9, 32'd9, "mul_rst");
    repeat (15) @(negedge clk);
    reset = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    q.delete();
    chk("midrst:busy", busy, 1'b0);
    chk("midrst:done", done, 1'b0);
    chk("midrst:result", result, 32'd0);
    repeat (40) @(negedge clk);   // monitor flags any done pulse here
    chk("midrst:idle_busy", busy, 1'b0);

    // Random operations
    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 3));
      issue(ro, $urandom, (i == 3) ? 32'd0 : $urandom, "rand");
      drain();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1);
  end

endmodule
